// File: rtl/sys_arr_drain.sv
// sys_arr_drain: output-side drain for the systolic array.
// Deskews the bottom-row column results (column c arrives c cycles after
// column 0) into aligned rows, buffers them in a small FIFO and hands them
// downstream over a valid/ready handshake.
module sys_arr_drain #(
    parameter int width_height = 2,
    parameter int fifo_depth   = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             clear,
    input  logic [16*width_height-1:0]       maccin,
    input  logic [width_height-1:0]          activein,
    output logic [16*width_height-1:0]       dout,
    output logic                             dout_valid,
    input  logic                             dout_ready,
    output logic [$clog2(fifo_depth):0]      count,
    output logic                             overflow,
    output logic                             skew_err
);

    localparam int PW = $clog2(fifo_depth);
    localparam int CW = PW + 1;
    localparam int RW = 16 * width_height;

    logic [RW-1:0]           w_alignRow;
    logic [width_height-1:0] w_alignAct;
    logic                    w_alignValid;
    logic                    w_skew;
    logic                    w_full;
    logic                    w_doPop;
    logic                    w_doPush;
    logic                    w_drop;

    logic [RW-1:0]           r_mem [fifo_depth];
    logic [PW-1:0]           r_wrPtr;
    logic [PW-1:0]           r_rdPtr;
    logic [CW-1:0]           r_count;
    logic                    r_overflow;
    logic                    r_skewErr;

    // Per-column delay lines: column c is held back width_height-1-c cycles
    // so that every column lines up with the last (undelayed) column.
    for (genvar c = 0; c < width_height; c++) begin : g_col
        if (c == width_height - 1) begin : g_direct
            assign w_alignRow[16*c +: 16] = maccin[16*c +: 16];
            assign w_alignAct[c]          = activein[c];
        end else begin : g_delay
            localparam int D = width_height - 1 - c;
            logic [15:0] r_sum [D];
            logic        r_act [D];

            // Shift sum and active bit one stage per cycle; clear only needs
            // to kill the active bits, stale sum data is harmless.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int k = 0; k < D; k++) begin
                        r_sum[k] <= '0;
                        r_act[k] <= 1'b0;
                    end
                end else begin
                    r_sum[0] <= maccin[16*c +: 16];
                    for (int k = 1; k < D; k++) r_sum[k] <= r_sum[k-1];
                    if (clear) begin
                        for (int k = 0; k < D; k++) r_act[k] <= 1'b0;
                    end else begin
                        r_act[0] <= activein[c];
                        for (int k = 1; k < D; k++) r_act[k] <= r_act[k-1];
                    end
                end
            end

            assign w_alignRow[16*c +: 16] = r_sum[D-1];
            assign w_alignAct[c]          = r_act[D-1];
        end
    end

    // The last column decides whether a row exists; any disagreement from the
    // delayed columns means the producer broke the one-cycle-per-column skew.
    assign w_alignValid = activein[width_height-1];
    assign w_skew       = |(w_alignAct ^ {width_height{w_alignValid}});

    assign dout_valid = (r_count != '0);
    assign w_full     = (r_count == CW'(fifo_depth));
    assign w_doPop    = dout_valid && dout_ready;
    assign w_doPush   = w_alignValid && (!w_full || w_doPop) && !clear;
    assign w_drop     = w_alignValid && w_full && !w_doPop;

    assign dout     = dout_valid ? r_mem[r_rdPtr] : '0;
    assign count    = r_count;
    assign overflow = r_overflow;
    assign skew_err = r_skewErr;

    // Row storage needs no reset: nothing is ever read from an empty slot.
    always_ff @(posedge clk) begin
        if (w_doPush) r_mem[r_wrPtr] <= w_alignRow;
    end

    // FIFO pointers, occupancy and the sticky overflow flag; clear wins over
    // any push or pop on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (clear) begin
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_doPush) r_wrPtr <= r_wrPtr + PW'(1);
            if (w_doPop)  r_rdPtr <= r_rdPtr + PW'(1);
            r_count <= r_count + CW'(w_doPush) - CW'(w_doPop);
            if (w_drop) r_overflow <= 1'b1;
        end
    end

    // Sticky skew error, cleared only by clear or reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_skewErr <= 1'b0;
        end else if (clear) begin
            r_skewErr <= 1'b0;
        end else if (w_skew) begin
            r_skewErr <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sys_arr_drain.sv
// tb_sys_arr_drain: directed bench for sys_arr_drain (2 columns, depth 4).
// Stimulus pushes expected rows into a scoreboard queue; a monitor pops and
// compares whenever the DUT hands a row downstream.
module tb_sys_arr_drain;

    logic        clk;
    logic        rst_n;
    logic        clear;
    logic [31:0] maccin;
    logic [1:0]  activein;
    logic [31:0] dout;
    logic        dout_valid;
    logic        dout_ready;
    logic [2:0]  count;
    logic        overflow;
    logic        skew_err;

    int          checks;
    int          errors;
    logic [31:0] expQ [$];

    sys_arr_drain #(
        .width_height(2),
        .fifo_depth  (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .maccin    (maccin),
        .activein  (activein),
        .dout      (dout),
        .dout_valid(dout_valid),
        .dout_ready(dout_ready),
        .count     (count),
        .overflow  (overflow),
        .skew_err  (skew_err)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so the run can never hang.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] timeout");
    end

    // Scoreboard monitor: a handshake is sampled mid-cycle and checked against
    // the oldest expected row.
    always @(negedge clk) begin
        if (rst_n && dout_valid && dout_ready) begin
            checks++;
            if (expQ.size() == 0) begin
                errors++;
                $display("[TB] FAIL popRow: got 0x%08h but no row was expected", dout);
            end else begin
                logic [31:0] expRow;
                expRow = expQ.pop_front();
                if (dout !== expRow) begin
                    errors++;
                    $display("[TB] FAIL popRow: got 0x%08h expected 0x%08h", dout, expRow);
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Drive one cycle of array outputs, then step to just after the next edge.
    task automatic applyStimulus(input logic [1:0] act, input logic [15:0] s0, input logic [15:0] s1);
        activein = act;
        maccin   = {s1, s0};
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(2'b00, 16'h0, 16'h0);
    endtask

    // One correctly skewed row: column 0 then column 1 a cycle later.
    task automatic pushRow(input logic [15:0] s0, input logic [15:0] s1);
        applyStimulus(2'b01, s0, 16'h0);
        applyStimulus(2'b10, 16'h0, s1);
    endtask

    task automatic doClear();
        clear = 1'b1;
        idle(1);
        clear = 1'b0;
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        rst_n      = 1'b0;
        clear      = 1'b0;
        dout_ready = 1'b0;
        activein   = 2'b00;
        maccin     = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("resetValid",    {31'h0, dout_valid}, 32'h0);
        checkOutput("resetCount",    {29'h0, count},      32'h0);
        checkOutput("resetDout",     dout,                32'h0);
        checkOutput("resetOverflow", {31'h0, overflow},   32'h0);
        checkOutput("resetSkew",     {31'h0, skew_err},   32'h0);
        rst_n = 1'b1;
        idle(2);

        // Basic deskew with back-to-back rows, downstream always ready.
        $display("[TB] basic deskew");
        dout_ready = 1'b1;
        expQ.push_back(32'h0009_0005);
        expQ.push_back(32'h000B_0007);
        applyStimulus(2'b01, 16'h0005, 16'h0000);
        applyStimulus(2'b11, 16'h0007, 16'h0009);
        checkOutput("basicCountFirst", {29'h0, count}, 32'd1);
        checkOutput("basicDoutFirst",  dout,           32'h0009_0005);
        applyStimulus(2'b10, 16'h0000, 16'h000B);
        checkOutput("basicDoutSecond", dout,           32'h000B_0007);
        idle(2);
        checkOutput("basicCountEnd", {29'h0, count},    32'd0);
        checkOutput("basicSkew",     {31'h0, skew_err}, 32'h0);

        // Backpressure: three rows held, head stable, then drained in order.
        $display("[TB] backpressure");
        dout_ready = 1'b0;
        pushRow(16'h1001, 16'h2001); expQ.push_back(32'h2001_1001);
        pushRow(16'h1002, 16'h2002); expQ.push_back(32'h2002_1002);
        pushRow(16'h1003, 16'h2003); expQ.push_back(32'h2003_1003);
        checkOutput("bpCount", {29'h0, count}, 32'd3);
        checkOutput("bpHead",  dout,           32'h2001_1001);
        idle(2);
        checkOutput("bpHeadStable", dout, 32'h2001_1001);
        dout_ready = 1'b1;
        idle(1);
        checkOutput("bpCountAfterOne", {29'h0, count}, 32'd2);
        idle(2);
        checkOutput("bpCountEnd", {29'h0, count}, 32'd0);

        // Overflow: five rows into a four-deep FIFO, the fifth is dropped.
        $display("[TB] overflow");
        dout_ready = 1'b0;
        pushRow(16'h3001, 16'h4001); expQ.push_back(32'h4001_3001);
        pushRow(16'h3002, 16'h4002); expQ.push_back(32'h4002_3002);
        pushRow(16'h3003, 16'h4003); expQ.push_back(32'h4003_3003);
        pushRow(16'h3004, 16'h4004); expQ.push_back(32'h4004_3004);
        checkOutput("ovfNotYet", {31'h0, overflow}, 32'h0);
        pushRow(16'h3005, 16'h4005);
        checkOutput("ovfCount", {29'h0, count},    32'd4);
        checkOutput("ovfFlag",  {31'h0, overflow}, 32'h1);
        dout_ready = 1'b1;
        idle(4);
        checkOutput("ovfDrained", {29'h0, count},    32'd0);
        checkOutput("ovfSticky",  {31'h0, overflow}, 32'h1);
        doClear();
        checkOutput("ovfCleared", {31'h0, overflow}, 32'h0);

        // Full FIFO, push and pop on the same edge.
        $display("[TB] full push+pop");
        dout_ready = 1'b0;
        pushRow(16'h5001, 16'h6001); expQ.push_back(32'h6001_5001);
        pushRow(16'h5002, 16'h6002); expQ.push_back(32'h6002_5002);
        pushRow(16'h5003, 16'h6003); expQ.push_back(32'h6003_5003);
        pushRow(16'h5004, 16'h6004); expQ.push_back(32'h6004_5004);
        checkOutput("fullCount", {29'h0, count}, 32'd4);
        expQ.push_back(32'h6005_5005);
        applyStimulus(2'b01, 16'h5005, 16'h0000);
        dout_ready = 1'b1;
        applyStimulus(2'b10, 16'h0000, 16'h6005);
        dout_ready = 1'b0;
        checkOutput("fullPpCount",    {29'h0, count},    32'd4);
        checkOutput("fullPpOverflow", {31'h0, overflow}, 32'h0);
        checkOutput("fullPpHead",     dout,              32'h6002_5002);
        dout_ready = 1'b1;
        idle(4);
        checkOutput("fullPpDrained", {29'h0, count}, 32'd0);

        // Skew error: column 1 active without a preceding column 0.
        $display("[TB] skew error");
        dout_ready = 1'b0;
        applyStimulus(2'b10, 16'h0000, 16'h00CC);
        checkOutput("skewFlag",  {31'h0, skew_err}, 32'h1);
        checkOutput("skewCount", {29'h0, count},    32'd1);
        checkOutput("skewRow",   dout,              32'h00CC_0000);
        idle(1);
        checkOutput("skewSticky", {31'h0, skew_err}, 32'h1);
        doClear();
        checkOutput("skewCleared",   {31'h0, skew_err},   32'h0);
        checkOutput("clearCount",    {29'h0, count},      32'd0);
        checkOutput("clearValid",    {31'h0, dout_valid}, 32'h0);

        // Asynchronous reset between edges with two rows buffered.
        $display("[TB] async reset");
        pushRow(16'h7001, 16'h8001);
        pushRow(16'h7002, 16'h8002);
        checkOutput("arCountBefore", {29'h0, count}, 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("arValid", {31'h0, dout_valid}, 32'h0);
        checkOutput("arCount", {29'h0, count},      32'd0);
        checkOutput("arDout",  dout,                32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(1);
        dout_ready = 1'b1;
        expQ.push_back(32'h8003_7003);
        pushRow(16'h7003, 16'h8003);
        checkOutput("arNewRow", dout, 32'h8003_7003);
        idle(2);
        checkOutput("arCountEnd", {29'h0, count}, 32'd0);

        checkOutput("scoreboardEmpty", expQ.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
